// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
// Includes the helper that finds the next channel still to be scanned.
package mux_scan_pkg;

  localparam int CH_W   = 2;
  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // One extra bit so the value NUM_CH can mean "no channel left".
  typedef logic [CH_W:0] chan_ext_t;

  function automatic chan_ext_t first_active(input chan_ext_t from,
                                             input logic [NUM_CH-1:0] skip);
    chan_ext_t r;
    r = chan_ext_t'(NUM_CH);
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (k >= int'(from) && !skip[k]) r = chan_ext_t'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-side signals of the scan controller.
// The slave modport is the controller; the master modport is its environment.
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic              start;
  logic              stop;
  logic [NUM_CH-1:0] mask;
  logic              y;
  logic              s1;
  logic              s0;
  logic              busy;
  logic [NUM_CH-1:0] frame;
  logic              frame_valid;
  logic              frame_ready;

  modport master (
    output start, stop, mask, y, frame_ready,
    input  s1, s0, busy, frame, frame_valid
  );

  modport slave (
    input  start, stop, mask, y, frame_ready,
    output s1, s0, busy, frame, frame_valid
  );

endinterface

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter: counts cycles spent on one channel and flags the last one.
// tc_o is qualified by inc_i so it only fires on a counting edge.
module mux_scan_dwell_cnt #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  logic [7:0] count_q;

  assign tc_o = inc_i && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= tc_o ? 8'd0 : count_q + 8'd1;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a downstream 4:1 mux, holding each select DWELL cycles, and offers the captured frame.
// Optional MUX_SCAN_SKIP_MASK_EN: channels flagged in mask (sampled at scan launch) are skipped.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL      = 4,
  parameter int CONTINUOUS = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_ctrl_if.slave bus
);

  state_e            state_q;
  logic [CH_W-1:0]   chan_q;
  logic [CH_W-1:0]   sel_q;
  logic [NUM_CH-1:0] shadow_q;
  logic [NUM_CH-1:0] frame_q;
  logic              frame_valid_q;
  logic              busy_q;
  logic              stop_pend_q;
  logic              empty_q;

  logic [NUM_CH-1:0] start_skip;
  logic [NUM_CH-1:0] scan_skip;
  logic [NUM_CH-1:0] shadow_d;
  chan_ext_t         entry_ch;
  chan_ext_t         next_ch;
  logic              handshake;
  logic              launch;
  logic              cnt_inc;
  logic              tc;

`ifdef MUX_SCAN_SKIP_MASK_EN
  logic [NUM_CH-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (launch) begin
      mask_q <= bus.mask;
    end
  end

  assign start_skip = bus.mask;
  assign scan_skip  = mask_q;
`else
  logic unused_mask;
  assign unused_mask = ^bus.mask;
  assign start_skip  = '0;
  assign scan_skip   = '0;
`endif

  assign entry_ch  = first_active('0, start_skip);
  assign next_ch   = first_active(chan_ext_t'(chan_q) + chan_ext_t'(1), scan_skip);
  assign handshake = (state_q == ST_HOLD) && frame_valid_q && bus.frame_ready;
  assign launch    = ((state_q == ST_IDLE) && bus.start && !bus.stop) ||
                     (handshake && (CONTINUOUS != 0) && !bus.stop && !stop_pend_q);

  // Counter only advances while the scan continues; any other edge reloads it to zero.
  assign cnt_inc = (state_q == ST_DWELL) && !bus.stop;

  always_comb begin
    shadow_d         = shadow_q;
    shadow_d[chan_q] = bus.y;
  end

  mux_scan_dwell_cnt #(.DWELL(DWELL)) u_dwell_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (!cnt_inc),
    .inc_i  (cnt_inc),
    .tc_o   (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      chan_q        <= '0;
      sel_q         <= '0;
      shadow_q      <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      stop_pend_q   <= 1'b0;
      empty_q       <= 1'b0;
    end else if (launch) begin
      state_q       <= ST_DWELL;
      chan_q        <= entry_ch[CH_W-1:0];
      sel_q         <= entry_ch[CH_W-1:0];
      shadow_q      <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b1;
      stop_pend_q   <= 1'b0;
      empty_q       <= entry_ch[CH_W];
    end else begin
      case (state_q)
        ST_DWELL: begin
          if (bus.stop) begin
            state_q  <= ST_IDLE;
            chan_q   <= '0;
            sel_q    <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
          end else if (empty_q) begin
            state_q       <= ST_HOLD;
            frame_q       <= '0;
            frame_valid_q <= 1'b1;
            empty_q       <= 1'b0;
          end else if (tc) begin
            shadow_q <= shadow_d;
            if (next_ch[CH_W]) begin
              state_q       <= ST_HOLD;
              chan_q        <= '0;
              sel_q         <= '0;
              frame_q       <= shadow_d;
              frame_valid_q <= 1'b1;
            end else begin
              chan_q <= next_ch[CH_W-1:0];
              sel_q  <= next_ch[CH_W-1:0];
            end
          end
        end
        ST_HOLD: begin
          // A stop seen while holding ends the run after this frame is taken.
          if (bus.stop) stop_pend_q <= 1'b1;
          if (handshake) begin
            state_q       <= ST_IDLE;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            stop_pend_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s1          = sel_q[1];
  assign bus.s0          = sel_q[0];
  assign bus.busy        = busy_q;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one-shot and continuous instances checked each cycle against a scan-timeline model.
// Directed checks with literal expected values pin the model at the key cycles.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  localparam int D = 4;
`ifdef MUX_SCAN_SKIP_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_scan_ctrl_if bus0 ();
  mux_scan_ctrl_if bus1 ();
  logic [3:0] ypat0 = 4'h0;
  logic [3:0] ypat1 = 4'h0;

  assign bus0.y = ypat0[{bus0.s1, bus0.s0}];
  assign bus1.y = ypat1[{bus1.s1, bus1.s0}];

  mux_scan_ctrl #(.DWELL(D), .CONTINUOUS(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mux_scan_ctrl #(.DWELL(D), .CONTINUOUS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a scan is a list of channels, each owning D consecutive cycles after launch.
  bit         m_scan[2];
  bit         m_hold[2];
  bit         m_sstop[2];
  int         m_el[2];
  int         m_nch[2];
  int         m_ch[2][4];
  logic [3:0] m_acc[2];

  task automatic m_launch(input int d, input logic [3:0] mask);
    m_scan[d]  = 1'b1;
    m_hold[d]  = 1'b0;
    m_sstop[d] = 1'b0;
    m_el[d]    = 0;
    m_acc[d]   = 4'h0;
    m_nch[d]   = 0;
    for (int k = 0; k < 4; k++) begin
      if (!(MASK_EN && mask[k])) begin
        m_ch[d][m_nch[d]] = k;
        m_nch[d]++;
      end
    end
  endtask

  task automatic m_edge(input int d, input bit cont, input logic rn, input logic st,
                        input logic sp, input logic [3:0] mask, input logic fr,
                        input logic [3:0] yp);
    int idx;
    int k;
    if (!rn) begin
      m_scan[d] = 1'b0;
      m_hold[d] = 1'b0;
    end else if (m_scan[d]) begin
      if (sp) begin
        m_scan[d] = 1'b0;
      end else if (m_nch[d] == 0) begin
        m_scan[d] = 1'b0;
        m_hold[d] = 1'b1;
      end else begin
        m_el[d]++;
        if (m_el[d] % D == 0) begin
          idx = m_el[d] / D - 1;
          k = m_ch[d][idx];
          m_acc[d][k] = yp[k];
          if (idx + 1 == m_nch[d]) begin
            m_scan[d] = 1'b0;
            m_hold[d] = 1'b1;
          end
        end
      end
    end else if (m_hold[d]) begin
      if (fr) begin
        m_hold[d] = 1'b0;
        if (cont && !sp && !m_sstop[d]) m_launch(d, mask);
      end else if (sp) begin
        m_sstop[d] = 1'b1;
      end
    end else if (st && !sp) begin
      m_launch(d, mask);
    end
  endtask

  always @(posedge clk) begin
    m_edge(0, 1'b0, rst_n, bus0.start, bus0.stop, bus0.mask, bus0.frame_ready, ypat0);
    m_edge(1, 1'b1, rst_n, bus1.start, bus1.stop, bus1.mask, bus1.frame_ready, ypat1);
  end

  task automatic cmp(input int d, input logic s1, input logic s0, input logic busy,
                     input logic [3:0] fr, input logic fv);
    logic [1:0] es;
    es = 2'b00;
    if (m_scan[d] && m_nch[d] > 0) es = 2'(m_ch[d][m_el[d] / D]);
    chk($sformatf("dut%0d_sel", d), 32'({s1, s0}), 32'(es));
    chk($sformatf("dut%0d_busy", d), 32'(busy), 32'(m_scan[d] || m_hold[d]));
    chk($sformatf("dut%0d_frame", d), 32'(fr), 32'(m_hold[d] ? m_acc[d] : 4'h0));
    chk($sformatf("dut%0d_frame_valid", d), 32'(fv), 32'(m_hold[d]));
  endtask

  always @(negedge clk) begin
    if (checking) begin
      cmp(0, bus0.s1, bus0.s0, bus0.busy, bus0.frame, bus0.frame_valid);
      cmp(1, bus1.s1, bus1.s0, bus1.busy, bus1.frame, bus1.frame_valid);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus0.start = 1'b0; bus0.stop = 1'b0; bus0.mask = 4'h0; bus0.frame_ready = 1'b0;
    bus1.start = 1'b0; bus1.stop = 1'b0; bus1.mask = 4'h0; bus1.frame_ready = 1'b0;
    step(2);
    checking = 1'b1;
    chk("reset_busy", 32'(bus0.busy), 32'h0);
    chk("reset_sel", 32'({bus0.s1, bus0.s0}), 32'h0);
    chk("reset_frame", 32'(bus0.frame), 32'h0);
    chk("reset_fv", 32'(bus0.frame_valid), 32'h0);
    rst_n = 1'b1;
    step(1);

    // Basic one-shot scan, with a start pulse during the scan that must be ignored
    ypat0 = 4'b1010; bus0.frame_ready = 1'b1; bus0.start = 1'b1;
    step(1); bus0.start = 1'b0;
    step(5); bus0.start = 1'b1;
    step(1); bus0.start = 1'b0;
    step(9);
    chk("scan_fv_before", 32'(bus0.frame_valid), 32'h0);
    step(1);
    $display("scan frame=%b fv=%b", bus0.frame, bus0.frame_valid);
    chk("scan_frame", 32'(bus0.frame), 32'b1010);
    chk("scan_fv", 32'(bus0.frame_valid), 32'h1);
    step(1);
    chk("scan_fv_drop", 32'(bus0.frame_valid), 32'h0);
    chk("scan_idle", 32'(bus0.busy), 32'h0);

    // Consumer stalls for 10 cycles
    step(2);
    ypat0 = 4'b0101; bus0.frame_ready = 1'b0; bus0.start = 1'b1;
    step(1); bus0.start = 1'b0;
    step(16);
    for (int i = 0; i < 10; i++) begin
      chk("stall_frame", 32'(bus0.frame), 32'b0101);
      chk("stall_fv", 32'(bus0.frame_valid), 32'h1);
      chk("stall_sel", 32'({bus0.s1, bus0.s0}), 32'h0);
      step(1);
    end
    bus0.frame_ready = 1'b1;
    step(1);
    $display("stall released fv=%b busy=%b", bus0.frame_valid, bus0.busy);
    chk("stall_drop", 32'(bus0.frame_valid), 32'h0);

    // Stop during channel 1
    step(2);
    ypat0 = 4'b1111; bus0.start = 1'b1;
    step(1); bus0.start = 1'b0;
    step(6);
    chk("stop_chan1", 32'({bus0.s1, bus0.s0}), 32'h1);
    bus0.stop = 1'b1;
    step(1); bus0.stop = 1'b0;
    $display("stop busy=%b fv=%b", bus0.busy, bus0.frame_valid);
    chk("stop_busy", 32'(bus0.busy), 32'h0);
    chk("stop_fv", 32'(bus0.frame_valid), 32'h0);
    step(20);

    // start and stop together stay idle
    bus0.start = 1'b1; bus0.stop = 1'b1;
    step(1); bus0.start = 1'b0; bus0.stop = 1'b0;
    chk("startstop_idle", 32'(bus0.busy), 32'h0);
    step(2);

    // Reset in the middle of a scan, then a clean scan
    ypat0 = 4'b1100; bus0.start = 1'b1;
    step(1); bus0.start = 1'b0;
    step(8); rst_n = 1'b0;
    step(1);
    chk("midrst_busy", 32'(bus0.busy), 32'h0);
    chk("midrst_sel", 32'({bus0.s1, bus0.s0}), 32'h0);
    chk("midrst_frame", 32'(bus0.frame), 32'h0);
    chk("midrst_fv", 32'(bus0.frame_valid), 32'h0);
    rst_n = 1'b1;
    step(1);
    ypat0 = 4'b0011; bus0.start = 1'b1;
    step(1); bus0.start = 1'b0;
    step(16);
    $display("post-reset frame=%b fv=%b", bus0.frame, bus0.frame_valid);
    chk("postrst_frame", 32'(bus0.frame), 32'b0011);
    chk("postrst_fv", 32'(bus0.frame_valid), 32'h1);
    step(2);

    // Skip mask
    ypat0 = 4'b1111; bus0.mask = 4'b0101; bus0.start = 1'b1;
    step(1); bus0.start = 1'b0; bus0.mask = 4'h0;
`ifdef MUX_SCAN_SKIP_MASK_EN
    step(7);
    chk("mask_fv_before", 32'(bus0.frame_valid), 32'h0);
    step(1);
    chk("mask_frame", 32'(bus0.frame), 32'b1010);
    chk("mask_fv", 32'(bus0.frame_valid), 32'h1);
    step(2);
    bus0.mask = 4'hF; bus0.start = 1'b1;
    step(1); bus0.start = 1'b0; bus0.mask = 4'h0;
    chk("maskall_fv_e0", 32'(bus0.frame_valid), 32'h0);
    step(1);
    chk("maskall_frame", 32'(bus0.frame), 32'h0);
    chk("maskall_fv", 32'(bus0.frame_valid), 32'h1);
`else
    step(16);
    chk("mask_ignored_frame", 32'(bus0.frame), 32'b1111);
    chk("mask_ignored_fv", 32'(bus0.frame_valid), 32'h1);
`endif
    $display("mask scan frame=%b fv=%b", bus0.frame, bus0.frame_valid);
    step(2);

    // Continuous mode: two back-to-back frames, then stop at the second handshake
    ypat1 = 4'b0110; bus1.frame_ready = 1'b1; bus1.start = 1'b1;
    step(1); bus1.start = 1'b0;
    step(16);
    chk("cont_frame1", 32'(bus1.frame), 32'b0110);
    chk("cont_fv1", 32'(bus1.frame_valid), 32'h1);
    ypat1 = 4'b1001;
    step(1);
    chk("cont_restart_fv", 32'(bus1.frame_valid), 32'h0);
    chk("cont_restart_busy", 32'(bus1.busy), 32'h1);
    chk("cont_restart_sel", 32'({bus1.s1, bus1.s0}), 32'h0);
    step(16);
    $display("continuous frame2=%b fv=%b", bus1.frame, bus1.frame_valid);
    chk("cont_frame2", 32'(bus1.frame), 32'b1001);
    chk("cont_fv2", 32'(bus1.frame_valid), 32'h1);
    bus1.stop = 1'b1;
    step(1); bus1.stop = 1'b0;
    chk("cont_stop_busy", 32'(bus1.busy), 32'h0);
    step(2);

    // Stop while holding keeps the frame, then ends in IDLE despite continuous mode
    ypat1 = 4'b0111; bus1.frame_ready = 1'b0; bus1.start = 1'b1;
    step(1); bus1.start = 1'b0;
    step(16);
    chk("holdstop_fv_rise", 32'(bus1.frame_valid), 32'h1);
    step(2); bus1.stop = 1'b1;
    step(1); bus1.stop = 1'b0;
    chk("holdstop_fv_kept", 32'(bus1.frame_valid), 32'h1);
    chk("holdstop_frame", 32'(bus1.frame), 32'b0111);
    step(3); bus1.frame_ready = 1'b1;
    step(1);
    $display("hold-stop handshake fv=%b busy=%b", bus1.frame_valid, bus1.busy);
    chk("holdstop_fv_drop", 32'(bus1.frame_valid), 32'h0);
    chk("holdstop_idle", 32'(bus1.busy), 32'h0);
    bus1.frame_ready = 1'b0;
    step(3);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
